// File: rtl/dpram_pkg.sv
// Shared definitions for the byte-enabled dual-port RAM family:
// read-during-write policy codes, clear FSM encoding and the byte merge helper.
package dpram_pkg;

   localparam int RDW_OLD = 0;
   localparam int RDW_NEW = 1;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   // One byte lane of a masked merge: take the new byte where enabled.
   function automatic logic [7:0] byte_merge(input logic [7:0] old_byte,
                                             input logic [7:0] new_byte,
                                             input logic       byteena);
      return byteena ? new_byte : old_byte;
   endfunction

endpackage

// File: rtl/dpram_be_core.sv
// Bare two-port RAM array with per-byte write masks and registered raw reads.
// Reads return the pre-write word; collision priority is resolved upstream.
module dpram_be_core #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 16
) (
   input  logic                      clock,
   input  logic                      we_a,
   input  logic [DATA_WIDTH/8-1:0]   be_a,
   input  logic [ADDR_WIDTH-1:0]     addr_a,
   input  logic [DATA_WIDTH-1:0]     wdata_a,
   input  logic                      re_a,
   output logic [DATA_WIDTH-1:0]     rdata_a,
   input  logic                      we_b,
   input  logic [DATA_WIDTH/8-1:0]   be_b,
   input  logic [ADDR_WIDTH-1:0]     addr_b,
   input  logic [DATA_WIDTH-1:0]     wdata_b,
   input  logic                      re_b,
   output logic [DATA_WIDTH-1:0]     rdata_b
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clock) begin
      for (int i = 0; i < DATA_WIDTH/8; i++) begin
         if (we_b && be_b[i]) mem[addr_b][8*i +: 8] <= wdata_b[8*i +: 8];
         if (we_a && be_a[i]) mem[addr_a][8*i +: 8] <= wdata_a[8*i +: 8];
      end
      if (re_a) rdata_a <= mem[addr_a];
      if (re_b) rdata_b <= mem[addr_b];
   end

endmodule

// File: rtl/dpram_be_clr.sv
// Dual-port byte-enabled RAM with hardware clear sequencer, fabric-side
// read-during-write forwarding, port A collision priority and optional output register.
//
//   state    | meaning
//   ST_CLEAR | writing CLEAR_VALUE to clr_addr each cycle; busy=1, user access blocked
//   ST_IDLE  | normal dual-port operation
module dpram_be_clr
   import dpram_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 10,
   parameter int                    DATA_WIDTH  = 16,
   parameter int                    RDW_MODE    = RDW_OLD,
   parameter int                    OUT_REG     = 0,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    clear,
   output logic                    busy,
   input  logic [ADDR_WIDTH-1:0]   address_a,
   input  logic [ADDR_WIDTH-1:0]   address_b,
   input  logic [DATA_WIDTH-1:0]   data_a,
   input  logic [DATA_WIDTH-1:0]   data_b,
   input  logic                    enable_a,
   input  logic                    enable_b,
   input  logic                    wren_a,
   input  logic                    wren_b,
   input  logic [DATA_WIDTH/8-1:0] byteena_a,
   input  logic [DATA_WIDTH/8-1:0] byteena_b,
   output logic [DATA_WIDTH-1:0]   q_a,
   output logic [DATA_WIDTH-1:0]   q_b
);

   localparam int BYTES = DATA_WIDTH/8;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
   logic                    busy_int, user_ok;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_CLEAR;
         clr_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      case (state_q)
         ST_CLEAR: begin
            if (clear) begin
               clr_addr_d = '0;
            end else begin
               clr_addr_d = clr_addr_q + 1'b1;
               if (clr_addr_q == '1) state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (clear) begin
               state_d    = ST_CLEAR;
               clr_addr_d = '0;
            end
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   assign busy_int = (state_q == ST_CLEAR);
   assign busy     = busy_int;
   assign user_ok  = ~busy_int & ~reset;

   logic             wr_a, wr_b, same_addr;
   logic [BYTES-1:0] be_b_eff;

   assign wr_a      = user_ok & enable_a & wren_a;
   assign wr_b      = user_ok & enable_b & wren_b;
   assign same_addr = (address_a == address_b);
   // Port A owns any byte both ports write to the same word.
   assign be_b_eff  = (wr_a && same_addr) ? (byteena_b & ~byteena_a) : byteena_b;

   logic [DATA_WIDTH-1:0] raw_a, raw_b;

   dpram_be_core #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_core (
      .clock   (clock),
      .we_a    (busy_int ? ~reset : wr_a),
      .be_a    (busy_int ? {BYTES{1'b1}} : byteena_a),
      .addr_a  (busy_int ? clr_addr_q : address_a),
      .wdata_a (busy_int ? CLEAR_VALUE : data_a),
      .re_a    (user_ok & enable_a),
      .rdata_a (raw_a),
      .we_b    (wr_b),
      .be_b    (be_b_eff),
      .addr_b  (address_b),
      .wdata_b (data_b),
      .re_b    (user_ok & enable_b),
      .rdata_b (raw_b)
   );

   logic [DATA_WIDTH-1:0] fwd_data_a, fwd_data_b, fwd_data_a_q, fwd_data_b_q;
   logic [BYTES-1:0]      fwd_mask_a, fwd_mask_b, fwd_mask_a_q, fwd_mask_b_q;
   logic                  vld_a_q, vld_b_q;

   // Bytes written this cycle to the word a port is reading; merged over the raw
   // (pre-write) array data when the new-data policy is selected.
   always_comb begin
      fwd_data_a = '0;
      fwd_data_b = '0;
      fwd_mask_a = '0;
      fwd_mask_b = '0;
      if (RDW_MODE == RDW_NEW) begin
         for (int i = 0; i < BYTES; i++) begin
            if (wr_a && byteena_a[i]) begin
               fwd_data_a[8*i +: 8] = data_a[8*i +: 8];
               fwd_mask_a[i]        = 1'b1;
            end else if (wr_b && same_addr && be_b_eff[i]) begin
               fwd_data_a[8*i +: 8] = data_b[8*i +: 8];
               fwd_mask_a[i]        = 1'b1;
            end
            if (wr_b && be_b_eff[i]) begin
               fwd_data_b[8*i +: 8] = data_b[8*i +: 8];
               fwd_mask_b[i]        = 1'b1;
            end else if (wr_a && same_addr && byteena_a[i]) begin
               fwd_data_b[8*i +: 8] = data_a[8*i +: 8];
               fwd_mask_b[i]        = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         vld_a_q      <= 1'b0;
         vld_b_q      <= 1'b0;
         fwd_data_a_q <= '0;
         fwd_data_b_q <= '0;
         fwd_mask_a_q <= '0;
         fwd_mask_b_q <= '0;
      end else begin
         vld_a_q      <= user_ok & enable_a;
         vld_b_q      <= user_ok & enable_b;
         fwd_data_a_q <= fwd_data_a;
         fwd_data_b_q <= fwd_data_b;
         fwd_mask_a_q <= fwd_mask_a;
         fwd_mask_b_q <= fwd_mask_b;
      end
   end

   logic [DATA_WIDTH-1:0] merged_a, merged_b, q1_a, q1_b;

   always_comb begin
      merged_a = '0;
      merged_b = '0;
      for (int i = 0; i < BYTES; i++) begin
         merged_a[8*i +: 8] = byte_merge(raw_a[8*i +: 8], fwd_data_a_q[8*i +: 8], fwd_mask_a_q[i]);
         merged_b[8*i +: 8] = byte_merge(raw_b[8*i +: 8], fwd_data_b_q[8*i +: 8], fwd_mask_b_q[i]);
      end
   end

   assign q1_a = vld_a_q ? merged_a : '0;
   assign q1_b = vld_b_q ? merged_b : '0;

   if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] q_a_r, q_b_r;
      always_ff @(posedge clock) begin
         if (reset) begin
            q_a_r <= '0;
            q_b_r <= '0;
         end else begin
            q_a_r <= q1_a;
            q_b_r <= q1_b;
         end
      end
      assign q_a = q_a_r;
      assign q_b = q_b_r;
   end else begin : g_out_comb
      assign q_a = q1_a;
      assign q_b = q1_b;
   end

endmodule
